// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS sequencing controller: states,
// opcodes, ALU operation codes and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_I_EXEC    = 4'd5,
    S_I_WB      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] ALU_OP_SUB   = 3'd1;
  localparam logic [2:0] ALU_OP_FUNCT = 3'd2;
  localparam logic [2:0] ALU_OP_OR    = 3'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  // Unsupported opcodes fall back to FETCH; the caller flags them as illegal.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:        return S_R_EXEC;
      OP_ADDI, OP_ORI: return S_I_EXEC;
      OP_LW, OP_SW:    return S_MEM_ADDR;
      OP_BEQ, OP_BNE:  return S_BRANCH;
      OP_J:            return S_JUMP;
      default:         return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath controls and counts retirements.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic [1:0]       pc_src_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             illegal_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] instr_count_o
);

  state_t state;
  state_t next_state;
  logic   retire;
  logic   illegal_now;

  logic pc_en_raw;
  logic ir_write_raw;
  logic mem_read_raw;
  logic mem_write_raw;
  logic reg_write_raw;

  always_comb begin
    next_state  = state;
    retire      = 1'b0;
    illegal_now = 1'b0;
    case (state)
      S_IDLE:      next_state = S_FETCH;
      S_FETCH:     if (mem_ready_i) next_state = S_DECODE;
      S_DECODE: begin
        next_state  = decode_next(opcode_i);
        illegal_now = (next_state == S_FETCH);
      end
      S_R_EXEC:    next_state = S_R_WB;
      S_I_EXEC:    next_state = S_I_WB;
      S_MEM_ADDR:  next_state = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready_i) next_state = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready_i) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      default:     next_state = S_IDLE;
    endcase
  end

  // With en_i low everything holds, including the one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      illegal_o     <= 1'b0;
      instr_done_o  <= 1'b0;
      instr_count_o <= '0;
    end else if (en_i) begin
      state        <= next_state;
      illegal_o    <= illegal_now;
      instr_done_o <= retire;
      if (retire) instr_count_o <= instr_count_o + CNT_W'(1);
    end
  end

  always_comb begin
    pc_en_raw     = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    pc_src_o      = PC_SRC_ALU;
    iord_o        = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRC_B_RT;
    alu_op_o      = ALU_OP_ADD;
    case (state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b_o  = SRC_B_FOUR;
        pc_en_raw    = mem_ready_i;
        ir_write_raw = mem_ready_i;
      end
      S_DECODE:    alu_src_b_o = SRC_B_IMM_SH2;
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        reg_dst_o     = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = (opcode_i == OP_ORI) ? ALU_OP_OR : ALU_OP_ADD;
      end
      S_I_WB:      reg_write_raw = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEM_READ: begin
        iord_o       = 1'b1;
        mem_read_raw = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg_o  = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEM_WRITE: begin
        iord_o        = 1'b1;
        mem_write_raw = 1'b1;
      end
      // opcode_i[0] separates bne (taken on nonzero) from beq.
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_SUB;
        pc_src_o    = PC_SRC_ALUOUT;
        pc_en_raw   = opcode_i[0] ? ~zero_i : zero_i;
      end
      S_JUMP: begin
        pc_src_o  = PC_SRC_JUMP;
        pc_en_raw = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en_o     = pc_en_raw & en_i;
  assign ir_write_o  = ir_write_raw & en_i;
  assign mem_read_o  = mem_read_raw & en_i;
  assign mem_write_o = mem_write_raw & en_i;
  assign reg_write_o = reg_write_raw & en_i;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm; a second instance
// with a 3-bit counter exercises counter wrap-around.
module tb_multicycle_control_fsm;

  typedef enum {
    PH_IDLE, PH_FETCH, PH_DECODE, PH_R_EXEC, PH_R_WB, PH_I_EXEC, PH_I_WB,
    PH_MEM_ADDR, PH_MEM_READ, PH_MEM_WB, PH_MEM_WRITE, PH_BRANCH, PH_JUMP
  } phase_t;

  typedef struct {
    phase_t      ph;
    logic [15:0] ctrl;
    logic        done;
    logic        ill;
    logic [31:0] cnt;
    logic [2:0]  cnt_s;
  } cyc_t;

  typedef struct {
    logic        ill;
    logic [31:0] cnt;
  } evt_t;

  logic        clk;
  logic        reset;
  logic        en_i;
  logic [5:0]  opcode_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic        reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0]  pc_src_o, alu_src_b_o;
  logic [2:0]  alu_op_o;
  logic        illegal_o, instr_done_o;
  logic [31:0] instr_count_o;

  logic        s_pc_en, s_iord, s_mem_read, s_mem_write, s_ir_write;
  logic        s_reg_dst, s_mem_to_reg, s_reg_write, s_alu_src_a;
  logic [1:0]  s_pc_src, s_alu_src_b;
  logic [2:0]  s_alu_op;
  logic        s_illegal, s_done;
  logic [2:0]  s_count;

  cyc_t        cyc_q[$];
  evt_t        evt_q[$];
  logic        pend_done;
  logic        pend_ill;
  logic [31:0] model_cnt;
  int          vectors;
  int          miscompares;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o),
    .pc_src_o(pc_src_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .illegal_o(illegal_o), .instr_done_o(instr_done_o),
    .instr_count_o(instr_count_o)
  );

  multicycle_control_fsm #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .en_i(en_i), .opcode_i(opcode_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_en_o(s_pc_en),
    .pc_src_o(s_pc_src), .iord_o(s_iord), .mem_read_o(s_mem_read),
    .mem_write_o(s_mem_write), .ir_write_o(s_ir_write), .reg_dst_o(s_reg_dst),
    .mem_to_reg_o(s_mem_to_reg), .reg_write_o(s_reg_write),
    .alu_src_a_o(s_alu_src_a), .alu_src_b_o(s_alu_src_b), .alu_op_o(s_alu_op),
    .illegal_o(s_illegal), .instr_done_o(s_done), .instr_count_o(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  // Control word the datapath should see in a given step of an instruction.
  function automatic logic [15:0] expect_ctrl(input phase_t ph, input logic en,
                                              input logic rdy, input logic [5:0] op,
                                              input logic z);
    logic       pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa;
    logic [1:0] pc_src, sb;
    logic [2:0] aop;
    {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa} = '0;
    pc_src = 2'd0;
    sb     = 2'd0;
    aop    = 3'd0;
    case (ph)
      PH_FETCH:     begin mrd = 1'b1; sb = 2'd1; pc_en = rdy; irw = rdy; end
      PH_DECODE:    sb = 2'd3;
      PH_R_EXEC:    begin sa = 1'b1; aop = 3'd2; end
      PH_R_WB:      begin rdst = 1'b1; rw = 1'b1; end
      PH_I_EXEC:    begin sa = 1'b1; sb = 2'd2; aop = (op == 6'h0D) ? 3'd3 : 3'd0; end
      PH_I_WB:      rw = 1'b1;
      PH_MEM_ADDR:  begin sa = 1'b1; sb = 2'd2; end
      PH_MEM_READ:  begin iord = 1'b1; mrd = 1'b1; end
      PH_MEM_WB:    begin m2r = 1'b1; rw = 1'b1; end
      PH_MEM_WRITE: begin iord = 1'b1; mwr = 1'b1; end
      PH_BRANCH:    begin sa = 1'b1; aop = 3'd1; pc_src = 2'd1;
                          pc_en = (op == 6'h04) ? z : !z; end
      PH_JUMP:      begin pc_src = 2'd2; pc_en = 1'b1; end
      default: ;
    endcase
    if (!en) {pc_en, irw, rw, mrd, mwr} = '0;
    return {pc_en, pc_src, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input phase_t ph);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t (%s): got 0x%0h want 0x%0h", name, $time,
               ph.name(), act, exp);
    end
  endtask

  task automatic checkOutput(input cyc_t c);
    evt_t e;
    cmp("ctrl", {16'd0, pc_en_o, pc_src_o, iord_o, mem_read_o, mem_write_o,
                 ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
                 alu_src_b_o, alu_op_o}, {16'd0, c.ctrl}, c.ph);
    cmp("pulses", {30'd0, instr_done_o, illegal_o}, {30'd0, c.done, c.ill}, c.ph);
    cmp("count", instr_count_o, c.cnt, c.ph);
    cmp("count_w3", {29'd0, s_count}, {29'd0, c.cnt_s}, c.ph);
    if (instr_done_o || illegal_o) begin
      if (evt_q.size() == 0) begin
        cmp("unexpected_event", 32'd1, 32'd0, c.ph);
      end else begin
        e = evt_q.pop_front();
        cmp("event_kind", {31'd0, illegal_o}, {31'd0, e.ill}, c.ph);
        cmp("event_count", instr_count_o, e.cnt, c.ph);
      end
    end
  endtask

  // Issue one clock cycle of inputs and record what the controller must show.
  task automatic applyStimulus(input phase_t ph, input logic en, input logic rdy,
                               input logic [5:0] op, input logic z,
                               input logic [1:0] fin, input logic rst_n);
    cyc_t c;
    evt_t e;
    reset       = rst_n;
    en_i        = en;
    mem_ready_i = rdy;
    opcode_i    = op;
    zero_i      = z;
    if (!rst_n) begin
      model_cnt = 32'd0;
      pend_done = 1'b0;
      pend_ill  = 1'b0;
      evt_q.delete();
    end
    c.ph    = ph;
    c.ctrl  = rst_n ? expect_ctrl(ph, en, rdy, op, z) : 16'd0;
    c.done  = pend_done;
    c.ill   = pend_ill;
    c.cnt   = model_cnt;
    c.cnt_s = model_cnt[2:0];
    cyc_q.push_back(c);
    if (rst_n && en) begin
      pend_done = (fin == 2'd1);
      pend_ill  = (fin == 2'd2);
      if (fin == 2'd1) model_cnt = model_cnt + 32'd1;
      if (fin != 2'd0) begin
        e.ill = (fin == 2'd2);
        e.cnt = model_cnt;
        evt_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic zval(input int zsel);
    return (zsel == 2) ? 1'($urandom) : 1'(zsel);
  endfunction

  // Plans one instruction as a list of enabled steps, then plays it with
  // optional en_i stalls and an optional reset at step index reset_at.
  task automatic runInstr(input logic [5:0] op, input int fwait, input int mwait,
                          input int zsel, input int stall_pct,
                          input phase_t stall_ph, input int stall_len,
                          input int reset_at);
    phase_t     ph_l[$];
    logic       rdy_l[$];
    logic [1:0] fin_l[$];
    logic [5:0] opv;
    logic       directed_done;
    int         n;
    directed_done = 1'b0;
    for (int i = 0; i < fwait; i++) begin
      ph_l.push_back(PH_FETCH); rdy_l.push_back(1'b0); fin_l.push_back(2'd0);
    end
    ph_l.push_back(PH_FETCH); rdy_l.push_back(1'b1); fin_l.push_back(2'd0);
    ph_l.push_back(PH_DECODE); rdy_l.push_back(1'($urandom));
    fin_l.push_back(is_legal(op) ? 2'd0 : 2'd2);
    case (op)
      6'h00: begin
        ph_l.push_back(PH_R_EXEC); rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd0);
        ph_l.push_back(PH_R_WB);   rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd1);
      end
      6'h08, 6'h0D: begin
        ph_l.push_back(PH_I_EXEC); rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd0);
        ph_l.push_back(PH_I_WB);   rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd1);
      end
      6'h23, 6'h2B: begin
        ph_l.push_back(PH_MEM_ADDR); rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd0);
        for (int i = 0; i <= mwait; i++) begin
          ph_l.push_back((op == 6'h23) ? PH_MEM_READ : PH_MEM_WRITE);
          rdy_l.push_back(i == mwait);
          fin_l.push_back((op == 6'h2B && i == mwait) ? 2'd1 : 2'd0);
        end
        if (op == 6'h23) begin
          ph_l.push_back(PH_MEM_WB); rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd1);
        end
      end
      6'h04, 6'h05: begin
        ph_l.push_back(PH_BRANCH); rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd1);
      end
      6'h02: begin
        ph_l.push_back(PH_JUMP); rdy_l.push_back(1'($urandom)); fin_l.push_back(2'd1);
      end
      default: ;
    endcase
    for (int i = 0; i < ph_l.size(); i++) begin
      opv = (ph_l[i] == PH_FETCH) ? 6'($urandom) : op;
      if (i == reset_at) begin
        applyStimulus(ph_l[i], 1'b1, 1'b1, opv, 1'b0, 2'd0, 1'b0);
        applyStimulus(PH_IDLE, 1'b1, 1'b1, opv, 1'b0, 2'd0, 1'b0);
        applyStimulus(PH_IDLE, 1'b0, 1'b1, opv, 1'b0, 2'd0, 1'b1);
        applyStimulus(PH_IDLE, 1'b1, 1'b0, opv, 1'b0, 2'd0, 1'b1);
        return;
      end
      n = 0;
      if (i > 0 && $urandom_range(99) < stall_pct) n = $urandom_range(3, 1);
      if (i > 0 && ph_l[i] == stall_ph && !directed_done) begin
        n = stall_len;
        directed_done = 1'b1;
      end
      for (int s = 0; s < n; s++)
        applyStimulus(ph_l[i], 1'b0, 1'($urandom), opv, zval(zsel), 2'd0, 1'b1);
      applyStimulus(ph_l[i], 1'b1, rdy_l[i], opv, zval(zsel), fin_l[i], 1'b1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) checkOutput(cyc_q.pop_front());
    end
  end

  initial begin
    logic [5:0] op_tab[8];
    logic [5:0] op;
    vectors     = 0;
    miscompares = 0;
    model_cnt   = 32'd0;
    pend_done   = 1'b0;
    pend_ill    = 1'b0;
    op_tab      = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    reset       = 1'b0;
    en_i        = 1'b0;
    opcode_i    = 6'h00;
    zero_i      = 1'b0;
    mem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(PH_IDLE, 1'b0, 1'b0, 6'h00, 1'b0, 2'd0, 1'b0);
    applyStimulus(PH_IDLE, 1'b0, 1'b1, 6'h00, 1'b0, 2'd0, 1'b1);
    applyStimulus(PH_IDLE, 1'b1, 1'b0, 6'h00, 1'b0, 2'd0, 1'b1);

    runInstr(6'h00, 0, 0, 2, 0, PH_IDLE, 0, -1);
    runInstr(6'h23, 0, 3, 2, 0, PH_IDLE, 0, -1);
    runInstr(6'h04, 0, 0, 1, 0, PH_IDLE, 0, -1);
    runInstr(6'h05, 0, 0, 1, 0, PH_IDLE, 0, -1);
    runInstr(6'h3F, 0, 0, 2, 0, PH_IDLE, 0, -1);
    runInstr(6'h2B, 0, 0, 2, 0, PH_MEM_WRITE, 5, -1);
    runInstr(6'h02, 0, 0, 2, 0, PH_IDLE, 0, -1);
    runInstr(6'h02, 0, 0, 2, 0, PH_IDLE, 0, -1);
    // Narrow counter sits at its maximum here; reset lands in MEM_ADDR.
    runInstr(6'h2B, 0, 0, 2, 0, PH_IDLE, 0, 2);
    for (int k = 0; k < 8; k++) runInstr(6'h02, 0, 0, 2, 0, PH_IDLE, 0, -1);

    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(9) == 0) ? 6'($urandom) : op_tab[$urandom_range(7)];
      runInstr(op, $urandom_range(2), $urandom_range(3), 2, 20, PH_IDLE, 0,
               ($urandom_range(14) == 0) ? $urandom_range(4, 1) : -1);
    end

    applyStimulus(PH_FETCH, 1'b1, 1'b0, 6'($urandom), 1'b0, 2'd0, 1'b1);
    applyStimulus(PH_FETCH, 1'b1, 1'b0, 6'($urandom), 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    #1;
    cmp("event_drain", evt_q.size(), 32'd0, PH_FETCH);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
